// File: rtl/key_pkg.sv
// key_pkg: types and constants shared by the key debounce front end.
//   key_st_e  - per-key debounce FSM states
//   pair_st_e - j/k pairing FSM states
//   SYNC_DEPTH - flops in each raw-key synchroniser
package key_pkg;
  localparam int SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_st_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_WAIT_J,
    P_WAIT_K
  } pair_st_e;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: one key's synchroniser, debounce counter and FSM.
//   clk, rst  - clock, synchronous active-high reset
//   key_i     - key, already polarity-corrected (1 = pressed), asynchronous
//   level_o   - debounced level (1 = pressed)
//   q_o       - one-cycle qualify event on a debounced press (none on release)
module key_debounce
  import key_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic level_o,
  output logic q_o
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  key_s;
  key_st_e               st_q, st_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic                  level_q, level_d;
  logic                  q_q, q_d;

  // Clearing to 0 ("released") means a key held through reset shows up as a
  // fresh press once the synchroniser refills.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_DEPTH-2:0], key_i};
  end

  assign key_s = sync_q[SYNC_DEPTH-1];

  // Saturating increment; never wraps back into a short count.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      q_q     <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      q_q     <= q_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    q_d     = 1'b0;
    case (st_q)
      IDLE: begin
        if (key_s) begin
          st_d  = PRESS_WAIT;
          cnt_d = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            st_d    = PRESSED;
            level_d = 1'b1;
            q_d     = 1'b1;
          end
        end
      end
      PRESSED: begin
        if (!key_s) begin
          st_d  = RELEASE_WAIT;
          cnt_d = CW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          st_d  = PRESSED;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            st_d    = IDLE;
            level_d = 1'b0;
          end
        end
      end
      default: begin
        st_d  = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  assign level_o = level_q;
  assign q_o     = q_q;
endmodule

// File: rtl/key_jk_debounce.sv
// key_jk_debounce: two raw push-buttons -> clean one-cycle j/k command pulses.
//   clk, rst             - clock, synchronous active-high reset
//   key_j_raw, key_k_raw - raw asynchronous buttons
//   j, k                 - registered one-cycle command pulses to the JK stage
//   j_level, k_level     - debounced key states (1 = pressed)
// A press on one key is held for up to PAIR_CYCLES cycles waiting for the
// other; if it arrives, j and k pulse together so the JK stage toggles.
module key_jk_debounce
  import key_pkg::*;
#(
  parameter int DEB_CYCLES     = 1000000,
  parameter int PAIR_CYCLES    = 16,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_j_raw,
  input  logic key_k_raw,
  output logic j,
  output logic k,
  output logic j_level,
  output logic k_level
);
  // Window counter width; kept at least 1 bit so PAIR_CYCLES=0 still elaborates.
  localparam int WW     = (PAIR_CYCLES > 0) ? $clog2(PAIR_CYCLES + 1) : 1;
  localparam int W_LAST = (PAIR_CYCLES > 0) ? PAIR_CYCLES - 1 : 0;

  // Index 0 = J, 1 = K.
  logic [1:0] key_act, lvl, qv;
  logic       q_j, q_k;

  assign key_act = KEY_ACTIVE_LOW ? ~{key_k_raw, key_j_raw} : {key_k_raw, key_j_raw};

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key [1:0] (
    .clk     (clk),
    .rst     (rst),
    .key_i   (key_act),
    .level_o (lvl),
    .q_o     (qv)
  );

  assign q_j = qv[0];
  assign q_k = qv[1];

  pair_st_e      pst_q, pst_d;
  logic [WW-1:0] w_q, w_d;
  logic          j_q, j_d, k_q, k_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      pst_q <= P_IDLE;
      w_q   <= '0;
      j_q   <= 1'b0;
      k_q   <= 1'b0;
    end else begin
      pst_q <= pst_d;
      w_q   <= w_d;
      j_q   <= j_d;
      k_q   <= k_d;
    end
  end

  always_comb begin
    pst_d = pst_q;
    w_d   = w_q;
    j_d   = 1'b0;
    k_d   = 1'b0;
    case (pst_q)
      P_IDLE: begin
        if (q_j && q_k) begin
          j_d = 1'b1;
          k_d = 1'b1;
        end else if (q_j) begin
          if (PAIR_CYCLES == 0) j_d = 1'b1;
          else begin
            pst_d = P_WAIT_J;
            w_d   = '0;
          end
        end else if (q_k) begin
          if (PAIR_CYCLES == 0) k_d = 1'b1;
          else begin
            pst_d = P_WAIT_K;
            w_d   = '0;
          end
        end
      end
      // A repeat q on the pending key is ignored; releasing it does not cancel.
      P_WAIT_J: begin
        if (q_k) begin
          j_d   = 1'b1;
          k_d   = 1'b1;
          pst_d = P_IDLE;
        end else if (w_q == WW'(W_LAST)) begin
          j_d   = 1'b1;
          pst_d = P_IDLE;
        end else begin
          w_d = w_q + WW'(1);
        end
      end
      P_WAIT_K: begin
        if (q_j) begin
          j_d   = 1'b1;
          k_d   = 1'b1;
          pst_d = P_IDLE;
        end else if (w_q == WW'(W_LAST)) begin
          k_d   = 1'b1;
          pst_d = P_IDLE;
        end else begin
          w_d = w_q + WW'(1);
        end
      end
      default: pst_d = P_IDLE;
    endcase
  end

  assign j       = j_q;
  assign k       = k_q;
  assign j_level = lvl[0];
  assign k_level = lvl[1];
endmodule

// File: tb/tb_key_jk_debounce.sv
module tb_key_jk_debounce;
  logic clk, rst, key_j_raw, key_k_raw;
  logic j, k, j_level, k_level;
  int total = 0;
  int bad   = 0;
  int jcnt  = 0;
  int kcnt  = 0;
  int jb, kb;

  key_jk_debounce #(.DEB_CYCLES(4), .PAIR_CYCLES(3), .KEY_ACTIVE_LOW(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_j_raw (key_j_raw),
    .key_k_raw (key_k_raw),
    .j         (j),
    .k         (k),
    .j_level   (j_level),
    .k_level   (k_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (j === 1'b1) jcnt++;
    if (k === 1'b1) kcnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all0(input string tag);
    chk({tag, "_j"}, j, 1'b0);
    chk({tag, "_k"}, k, 1'b0);
    chk({tag, "_jl"}, j_level, 1'b0);
    chk({tag, "_kl"}, k_level, 1'b0);
  endtask

  initial begin
    rst = 1'b1; key_j_raw = 1'b1; key_k_raw = 1'b1;
    tick(3);
    chk_all0("reset");
    rst = 1'b0;
    tick(2);
    chk_all0("post_reset");

    // Bounce on J: 1,0,1,0 then held 0 (pressed).
    jb = jcnt; kb = kcnt;
    key_j_raw = 1'b0; tick(1);
    key_j_raw = 1'b1; tick(1);
    key_j_raw = 1'b0;
    tick(5); chk("bounce_jl_early", j_level, 1'b0);
    tick(1); chk("bounce_jl_rise", j_level, 1'b1);
    tick(3); chk("bounce_j_before", j, 1'b0);
    tick(1); chk("bounce_j_pulse", j, 1'b1);
    tick(1); chk("bounce_j_after", j, 1'b0);
    tick(3);
    chki("bounce_jcount", jcnt - jb, 1);
    chki("bounce_kcount", kcnt - kb, 0);

    // Release J with 3 bounces, final rise then stable.
    jb = jcnt; kb = kcnt;
    key_j_raw = 1'b1; tick(1);
    key_j_raw = 1'b0; tick(1);
    key_j_raw = 1'b1; tick(1);
    key_j_raw = 1'b0; tick(1);
    key_j_raw = 1'b1;
    tick(5); chk("rel_jl_held", j_level, 1'b1);
    tick(1); chk("rel_jl_fall", j_level, 1'b0);
    tick(8);
    chki("rel_jcount", jcnt - jb, 0);
    chki("rel_kcount", kcnt - kb, 0);

    // Lone K press.
    jb = jcnt; kb = kcnt;
    key_k_raw = 1'b0;
    tick(5); chk("lone_kl_early", k_level, 1'b0);
    tick(1); chk("lone_kl_rise", k_level, 1'b1);
    tick(3); chk("lone_k_before", k, 1'b0);
    tick(1); chk("lone_k_pulse", k, 1'b1);
    tick(1); chk("lone_k_after", k, 1'b0);
    chki("lone_jcount", jcnt - jb, 0);
    key_k_raw = 1'b1;
    tick(8); chk("lone_kl_rel", k_level, 1'b0);
    chki("lone_kcount", kcnt - kb, 1);

    // Paired: K falls 2 cycles after J.
    jb = jcnt; kb = kcnt;
    key_j_raw = 1'b0; tick(2);
    key_k_raw = 1'b0;
    tick(6); chk("pair_j_before", j, 1'b0); chk("pair_k_before", k, 1'b0);
    tick(1); chk("pair_j", j, 1'b1); chk("pair_k", k, 1'b1);
    tick(1); chk("pair_j_after", j, 1'b0); chk("pair_k_after", k, 1'b0);
    tick(8);
    chki("pair_jcount", jcnt - jb, 1);
    chki("pair_kcount", kcnt - kb, 1);
    key_j_raw = 1'b1; key_k_raw = 1'b1;
    tick(10);
    chk("pair_jl_rel", j_level, 1'b0); chk("pair_kl_rel", k_level, 1'b0);

    // Late pair: K falls 5 cycles after J -> two separate pulses.
    jb = jcnt; kb = kcnt;
    key_j_raw = 1'b0; tick(5);
    key_k_raw = 1'b0;
    tick(5); chk("late_j", j, 1'b1); chk("late_k_none", k, 1'b0);
    tick(1); chk("late_j_after", j, 1'b0);
    tick(3); chk("late_k_before", k, 1'b0);
    tick(1); chk("late_k", k, 1'b1); chk("late_j_none", j, 1'b0);
    tick(1); chk("late_k_after", k, 1'b0);
    chki("late_jcount", jcnt - jb, 1);
    chki("late_kcount", kcnt - kb, 1);
    key_j_raw = 1'b1; key_k_raw = 1'b1;
    tick(10);

    // Reset 2 cycles into PRESS_WAIT with J held.
    jb = jcnt; kb = kcnt;
    key_j_raw = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1); chk_all0("rst_mid0");
    tick(1); chk_all0("rst_mid1");
    tick(1); chk_all0("rst_mid2");
    rst = 1'b0;
    tick(5); chk("rst_jl_early", j_level, 1'b0);
    tick(1); chk("rst_jl_rise", j_level, 1'b1);
    tick(3); chk("rst_j_before", j, 1'b0);
    tick(1); chk("rst_j_pulse", j, 1'b1);
    tick(1); chk("rst_j_after", j, 1'b0);
    chki("rst_jcount", jcnt - jb, 1);
    chki("rst_kcount", kcnt - kb, 0);
    key_j_raw = 1'b1;
    tick(10);
    chk_all0("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
